// File: rtl/packed_struct_array_streamer_pkg.sv
// Shared types for the frame streamer: the element struct, the frame union and its geometry.
// Rows are K+1 and columns J+1. Element [r][c] sits at frame bits 3*((J+1)*r+c) +: 3.
package packed_struct_array_streamer_pkg;

    localparam int J      = 3;
    localparam int K      = 2;
    localparam int ELEM_W = 3;
    localparam int ELEMS  = (K + 1) * (J + 1);
    localparam int ROW_W  = (K > 0) ? $clog2(K + 1) : 1;
    localparam int COL_W  = (J > 0) ? $clog2(J + 1) : 1;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
    } my_packed_struct_t;

    // The 2-D view and the flat view alias the same bits.
    typedef union packed {
        my_packed_struct_t [K:0][J:0] my_array;
        logic [ELEMS*ELEM_W-1:0]      flat;
    } my_packed_union_with_array_t;

    typedef my_packed_union_with_array_t frame_t;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

endpackage

// File: rtl/packed_struct_index_counter.sv
// Row/column walker over the frame grid. It wraps col then row, ascending or descending per REVERSE.
// It flags the first and last grid positions, and after the last position it comes back to the start on its own.
module packed_struct_index_counter
    import packed_struct_array_streamer_pkg::*;
#(
    parameter bit REVERSE = 1'b0
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_at_start,
    output logic             o_at_end
);

    localparam logic [ROW_W-1:0] ROW_FIRST = REVERSE ? ROW_W'(K) : '0;
    localparam logic [ROW_W-1:0] ROW_LAST  = REVERSE ? '0 : ROW_W'(K);
    localparam logic [COL_W-1:0] COL_FIRST = REVERSE ? COL_W'(J) : '0;
    localparam logic [COL_W-1:0] COL_LAST  = REVERSE ? '0 : COL_W'(J);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] w_row_next;
    logic [COL_W-1:0] w_col_next;
    logic             w_row_at_last;
    logic             w_col_at_last;

    assign w_row_at_last = (r_row == ROW_LAST);
    assign w_col_at_last = (r_col == COL_LAST);

    always_comb begin
        w_row_next = r_row;
        w_col_next = r_col;
        if (i_adv) begin
            if (w_col_at_last) begin
                w_col_next = COL_FIRST;
                if (w_row_at_last) begin
                    w_row_next = ROW_FIRST;
                end else begin
                    w_row_next = REVERSE ? (r_row - 1'b1) : (r_row + 1'b1);
                end
            end else begin
                w_col_next = REVERSE ? (r_col - 1'b1) : (r_col + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row <= ROW_FIRST;
            r_col <= COL_FIRST;
        end else begin
            r_row <= w_row_next;
            r_col <= w_col_next;
        end
    end

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_at_start = (r_row == ROW_FIRST) && (r_col == COL_FIRST);
    assign o_at_end   = w_row_at_last && w_col_at_last;

endmodule

// File: rtl/packed_struct_array_streamer.sv
// Accepts one packed frame per handshake and streams its 3-bit elements out, one element per beat.
// Defining PKT_STREAM_PARITY_EN adds an odd-parity output, out_par, that covers out_elem.
module packed_struct_array_streamer
    import packed_struct_array_streamer_pkg::*;
#(
    parameter bit REVERSE     = 1'b0,
    parameter int STALL_CNT_W = 8
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  frame_t                 in_frame,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ELEM_W-1:0]      out_elem,
    output logic [ROW_W-1:0]       out_row,
    output logic [COL_W-1:0]       out_col,
    output logic                   out_first,
    output logic                   out_last,
    output logic [STALL_CNT_W-1:0] stall_cnt
`ifdef PKT_STREAM_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    state_t                  r_state;
    state_t                  w_state_next;
    frame_t                  r_frame;
    logic [STALL_CNT_W-1:0]  r_stall_cnt;
    logic                    w_capture;
    logic                    w_beat;
    logic [ROW_W-1:0]        w_row;
    logic [COL_W-1:0]        w_col;
    logic                    w_at_start;
    logic                    w_at_end;
    my_packed_struct_t       w_elem;

    packed_struct_index_counter #(
        .REVERSE (REVERSE)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (w_beat),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_at_start (w_at_start),
        .o_at_end   (w_at_end)
    );

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_capture    = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (w_at_end) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_frame <= in_frame;
            end
            if ((r_state == ST_STREAM) && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // The element is read from registered frame and index only, so no input reaches these outputs combinationally.
    assign w_elem    = r_frame.my_array[w_row][w_col];
    assign out_elem  = w_elem;
    assign out_row   = w_row;
    assign out_col   = w_col;
    assign out_first = out_valid && w_at_start;
    assign out_last  = out_valid && w_at_end;
    assign stall_cnt = r_stall_cnt;

`ifdef PKT_STREAM_PARITY_EN
    assign out_par = out_valid & ~(^w_elem);
`endif

endmodule

// File: tb/tb_packed_struct_array_streamer.sv
// Directed bench: a forward and a reversed streamer share stimulus, and a frame-queue model checks every cycle.
// Set PKT_STREAM_PARITY_EN to cover out_par as well.
module tb_packed_struct_array_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [35:0] in_frame;
    logic        out_ready;

    logic        in_ready, out_valid, out_first, out_last;
    logic [2:0]  out_elem;
    logic [1:0]  out_row, out_col;
    logic [7:0]  stall_cnt;
    logic        rv_in_ready, rv_out_valid, rv_out_first, rv_out_last;
    logic [2:0]  rv_out_elem;
    logic [1:0]  rv_out_row, rv_out_col;
    logic [7:0]  rv_stall_cnt;
`ifdef PKT_STREAM_PARITY_EN
    logic        out_par, rv_out_par;
`endif

    always #5 clk = ~clk;

    packed_struct_array_streamer #(.REVERSE(1'b0), .STALL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_frame(in_frame),
        .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem), .out_row(out_row),
        .out_col(out_col), .out_first(out_first), .out_last(out_last), .stall_cnt(stall_cnt)
`ifdef PKT_STREAM_PARITY_EN
        , .out_par(out_par)
`endif
    );

    packed_struct_array_streamer #(.REVERSE(1'b1), .STALL_CNT_W(8)) dut_rev (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rv_in_ready), .in_frame(in_frame),
        .out_valid(rv_out_valid), .out_ready(out_ready), .out_elem(rv_out_elem), .out_row(rv_out_row),
        .out_col(rv_out_col), .out_first(rv_out_first), .out_last(rv_out_last), .stall_cnt(rv_stall_cnt)
`ifdef PKT_STREAM_PARITY_EN
        , .out_par(rv_out_par)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: an accepted frame becomes a list of expected beats, and each beat is consumed when out_ready is high.
    typedef struct {
        int fe, fr, fc;
        int re, rr, rc;
        int first, last;
    } exp_t;

    exp_t m_q[$];
    int   m_stall = 0;
    int   cycle = 0;

    always @(posedge clk) begin
        logic [35:0] f;
        exp_t e;
        int ri;
        cycle++;
        if (rst) begin
            m_q.delete();
            m_stall = 0;
        end else if (m_q.size() == 0) begin
            if (in_valid) begin
                f = in_frame;
                for (int i = 0; i < 12; i++) begin
                    ri = 11 - i;
                    e.fe = int'(f[3*i +: 3]);
                    e.fr = i / 4;
                    e.fc = i % 4;
                    e.re = int'(f[3*ri +: 3]);
                    e.rr = ri / 4;
                    e.rc = ri % 4;
                    e.first = (i == 0) ? 1 : 0;
                    e.last  = (i == 11) ? 1 : 0;
                    m_q.push_back(e);
                end
            end
        end else if (out_ready) begin
            void'(m_q.pop_front());
        end else if (m_stall != 255) begin
            m_stall++;
        end
    end

    int log_elem[$], log_row[$], log_col[$], log_first[$], log_last[$];
    int rlog_elem[$], rlog_row[$], rlog_col[$];
    int last_cyc[$], hs_cyc[$];
    int beat_total = 0;
    int hs_total = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, (m_q.size() == 0) ? 1 : 0);
            chk("out_valid", out_valid, (m_q.size() != 0) ? 1 : 0);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("rv_in_ready", rv_in_ready, (m_q.size() == 0) ? 1 : 0);
            chk("rv_out_valid", rv_out_valid, (m_q.size() != 0) ? 1 : 0);
            chk("rv_stall_cnt", rv_stall_cnt, m_stall);
            if (m_q.size() != 0) begin
                chk("out_elem", out_elem, m_q[0].fe);
                chk("out_row", out_row, m_q[0].fr);
                chk("out_col", out_col, m_q[0].fc);
                chk("out_first", out_first, m_q[0].first);
                chk("out_last", out_last, m_q[0].last);
                chk("rv_out_elem", rv_out_elem, m_q[0].re);
                chk("rv_out_row", rv_out_row, m_q[0].rr);
                chk("rv_out_col", rv_out_col, m_q[0].rc);
                chk("rv_out_first", rv_out_first, m_q[0].first);
                chk("rv_out_last", rv_out_last, m_q[0].last);
`ifdef PKT_STREAM_PARITY_EN
                chk("out_par", out_par, ($countones(m_q[0].fe) % 2 == 0) ? 1 : 0);
                chk("rv_out_par", rv_out_par, ($countones(m_q[0].re) % 2 == 0) ? 1 : 0);
`endif
            end else begin
`ifdef PKT_STREAM_PARITY_EN
                chk("out_par_idle", out_par, 0);
`endif
            end
        end
        if (!rst && out_valid && out_ready) begin
            log_elem.push_back(int'(out_elem));
            log_row.push_back(int'(out_row));
            log_col.push_back(int'(out_col));
            log_first.push_back(int'(out_first));
            log_last.push_back(int'(out_last));
            if (out_last) last_cyc.push_back(cycle);
            beat_total++;
        end
        if (!rst && rv_out_valid && out_ready) begin
            rlog_elem.push_back(int'(rv_out_elem));
            rlog_row.push_back(int'(rv_out_row));
            rlog_col.push_back(int'(rv_out_col));
        end
        if (!rst && in_valid && in_ready) begin
            hs_total++;
            hs_cyc.push_back(cycle);
            $display("frame accepted cycle %0d data %09h", cycle, in_frame);
        end
    end

    // Offers f, then switches in_frame to f2 after the first handshake. in_valid drops after nframes handshakes,
    // and the task returns once stop_beats beats have completed. mode 1 toggles out_ready every cycle.
    task automatic run_frame(input logic [35:0] f, input logic [35:0] f2, input int nframes,
                             input int mode, input int stop_beats);
        int  hs0, b0;
        bit  done;
        hs0 = hs_total;
        b0  = beat_total;
        done = 1'b0;
        in_frame  = f;
        in_valid  = 1'b1;
        out_ready = (mode == 1) ? 1'b0 : 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(posedge clk);
            #1;
            if (hs_total - hs0 >= 1) in_frame = f2;
            if (hs_total - hs0 >= nframes) in_valid = 1'b0;
            if (mode == 1) out_ready = ~out_ready;
            if (beat_total - b0 >= stop_beats) done = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!done) chk("run_frame_timeout", 0, 1);
    endtask

    localparam logic [35:0] F1 = {12'b000000000000, 12'b101010111000, 12'b111000101010};
    localparam logic [35:0] F2 = 36'hFEDCBA98D;

    initial begin
        int exp2[12] = '{2, 5, 0, 7, 0, 7, 2, 5, 0, 0, 0, 0};
        int b, rb, lb, hb;
        rst = 1'b1;
        in_valid = 1'b0;
        in_frame = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_elem", out_elem, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Forward stream with no back-pressure.
        b = log_elem.size();
        rb = rlog_elem.size();
        run_frame(F1, F1, 1, 0, 12);
        chk("t2_beats", log_elem.size() - b, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t2_elem%0d", i), log_elem[b+i], exp2[i]);
        chk("t2_first_beat1", log_first[b], 1);
        chk("t2_first_beat2", log_first[b+1], 0);
        chk("t2_last_beat11", log_last[b+10], 0);
        chk("t2_last_beat12", log_last[b+11], 1);
        chk("t2_in_ready_after", in_ready, 1);

        // Reversed instance over the same frame.
        chk("t4_rev_first_elem", rlog_elem[rb], 0);
        chk("t4_rev_first_row", rlog_row[rb], 2);
        chk("t4_rev_first_col", rlog_col[rb], 3);
        chk("t4_rev_last_elem", rlog_elem[rb+11], 2);
        chk("t4_rev_last_row", rlog_row[rb+11], 0);
        chk("t4_rev_last_col", rlog_col[rb+11], 0);

        // Alternating back-pressure.
        b = log_elem.size();
        run_frame(F1, F1, 1, 1, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t3_elem%0d", i), log_elem[b+i], exp2[i]);
        chk("t3_stall_cnt", stall_cnt, 11);

        // in_valid held high for two frames: a one-cycle bubble separates them.
        lb = last_cyc.size();
        hb = hs_cyc.size();
        run_frame(F1, F2, 2, 0, 24);
        chk("t5_hs_count", hs_cyc.size() - hb, 2);
        chk("t5_gap", hs_cyc[hb+1] - last_cyc[lb], 1);

        // Reset in the middle of a frame.
        run_frame(F1, F1, 1, 0, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_stall_cleared", stall_cnt, 0);
        b = log_elem.size();
        run_frame(F2, F2, 1, 0, 12);
        chk("t6_first_elem", log_elem[b], 5);
        chk("t6_first_row", log_row[b], 0);
        chk("t6_first_col", log_col[b], 0);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
